// File: rtl/clock_pkg.sv
// Shared types, limits and BCD helpers for the time-setting clock.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } state_t;

    localparam int unsigned HOUR_MAX           = 23;
    localparam int unsigned MIN_MAX            = 59;
    localparam int unsigned SEC_MAX            = 59;
    localparam int unsigned DEB_CYCLES_DEFAULT = 50000;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_pair_t;

    function automatic logic bcd_is_max(input bcd_pair_t v, input int unsigned max_val);
        return (v.tens == 4'(max_val / 10)) && (v.ones == 4'(max_val % 10));
    endfunction

    // Increment a two-digit BCD field, wrapping to 00 past max_val.
    function automatic bcd_pair_t bcd_inc(input bcd_pair_t v, input int unsigned max_val);
        bcd_pair_t r;
        if (bcd_is_max(v, max_val)) begin
            r = '0;
        end else if (v.ones == 4'd9) begin
            r.tens = v.tens + 4'd1;
            r.ones = 4'd0;
        end else begin
            r.tens = v.tens;
            r.ones = v.ones + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop synchronizer -> counting debouncer -> single-cycle press pulse.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = clock_pkg::DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter tracks consecutive samples disagreeing with the accepted level.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = level_d & ~level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Clock time keeper with button-driven RUN / SET_HOUR / SET_MIN editing, BCD digit outputs.
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] hour_tens,
    output logic [3:0] hour_ones,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [1:0] mode,
    output logic       blink
);

    logic mode_p, inc_p;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk     (clk),
        .rst_n   (rst),
        .btn_raw (btn_mode),
        .press   (mode_p)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
        .clk     (clk),
        .rst_n   (rst),
        .btn_raw (btn_inc),
        .press   (inc_p)
    );

    state_t    state_q, state_d;
    bcd_pair_t hour_q, hour_d;
    bcd_pair_t min_q, min_d;
    bcd_pair_t sec_q, sec_d;
    logic      blink_q, blink_d;

    // A mode press always takes priority over inc and tick in the same cycle.
    always_comb begin
        state_d = state_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        blink_d = blink_q;
        case (state_q)
            RUN: begin
                blink_d = 1'b0;
                if (mode_p) begin
                    state_d = SET_HOUR;
                    sec_d   = '0;
                end else if (tick_1hz) begin
                    sec_d = bcd_inc(sec_q, SEC_MAX);
                    if (bcd_is_max(sec_q, SEC_MAX)) begin
                        min_d = bcd_inc(min_q, MIN_MAX);
                        if (bcd_is_max(min_q, MIN_MAX)) begin
                            hour_d = bcd_inc(hour_q, HOUR_MAX);
                        end
                    end
                end
            end
            SET_HOUR: begin
                sec_d = '0;
                if (mode_p) begin
                    state_d = SET_MIN;
                    blink_d = 1'b0;
                end else begin
                    if (inc_p)    hour_d  = bcd_inc(hour_q, HOUR_MAX);
                    if (tick_1hz) blink_d = ~blink_q;
                end
            end
            SET_MIN: begin
                sec_d = '0;
                if (mode_p) begin
                    state_d = RUN;
                    blink_d = 1'b0;
                end else begin
                    if (inc_p)    min_d   = bcd_inc(min_q, MIN_MAX);
                    if (tick_1hz) blink_d = ~blink_q;
                end
            end
            default: begin
                state_d = RUN;
                blink_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            hour_q  <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            blink_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            blink_q <= blink_d;
        end
    end

    assign hour_tens = hour_q.tens;
    assign hour_ones = hour_q.ones;
    assign min_tens  = min_q.tens;
    assign min_ones  = min_q.ones;
    assign sec_tens  = sec_q.tens;
    assign sec_ones  = sec_q.ones;
    assign mode      = state_q;
    assign blink     = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with DEB_CYCLES=4: vector table plus timing corner sequences.
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones;
    logic [1:0] mode;
    logic       blink;

    int total = 0;
    int bad   = 0;

    time_set_ctrl #(.DEB_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_1hz  (tick_1hz),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .hour_tens (hour_tens),
        .hour_ones (hour_ones),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .mode      (mode),
        .blink     (blink)
    );

    always #5 clk = ~clk;

    typedef enum int {OP_MODE, OP_INC, OP_TICK} op_t;

    typedef struct {
        op_t        op;
        int         n;
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
        logic [1:0] md;
        logic       bl;
    } vec_t;

    vec_t vecs[17];

    function automatic logic [26:0] mk(input logic [7:0] h, input logic [7:0] m,
                                       input logic [7:0] s, input logic [1:0] md, input logic bl);
        return {h, m, s, md, bl};
    endfunction

    task automatic check(input string name, input logic [26:0] exp);
        logic [26:0] act;
        act = {hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones, mode, blink};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h:%h:%h mode=%0d blink=%b, want %h:%h:%h mode=%0d blink=%b",
                     name, act[26:19], act[18:11], act[10:3], act[2:1], act[0],
                     exp[26:19], exp[18:11], exp[10:3], exp[2:1], exp[0]);
        end
    endtask

    task automatic press(input int which);
        @(posedge clk); #1;
        if (which == 0) btn_mode = 1'b1; else btn_inc = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    task automatic press_both();
        @(posedge clk); #1;
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    task automatic tick();
        @(posedge clk); #1 tick_1hz = 1'b1;
        @(posedge clk); #1 tick_1hz = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{OP_MODE, 1,  8'h00, 8'h00, 8'h00, 2'd1, 1'b0};
        vecs[1]  = '{OP_INC,  23, 8'h23, 8'h00, 8'h00, 2'd1, 1'b0};
        vecs[2]  = '{OP_INC,  1,  8'h00, 8'h00, 8'h00, 2'd1, 1'b0};
        vecs[3]  = '{OP_INC,  23, 8'h23, 8'h00, 8'h00, 2'd1, 1'b0};
        vecs[4]  = '{OP_MODE, 1,  8'h23, 8'h00, 8'h00, 2'd2, 1'b0};
        vecs[5]  = '{OP_INC,  59, 8'h23, 8'h59, 8'h00, 2'd2, 1'b0};
        vecs[6]  = '{OP_INC,  1,  8'h23, 8'h00, 8'h00, 2'd2, 1'b0};
        vecs[7]  = '{OP_INC,  59, 8'h23, 8'h59, 8'h00, 2'd2, 1'b0};
        vecs[8]  = '{OP_TICK, 1,  8'h23, 8'h59, 8'h00, 2'd2, 1'b1};
        vecs[9]  = '{OP_TICK, 1,  8'h23, 8'h59, 8'h00, 2'd2, 1'b0};
        vecs[10] = '{OP_TICK, 1,  8'h23, 8'h59, 8'h00, 2'd2, 1'b1};
        vecs[11] = '{OP_MODE, 1,  8'h23, 8'h59, 8'h00, 2'd0, 1'b0};
        vecs[12] = '{OP_TICK, 58, 8'h23, 8'h59, 8'h58, 2'd0, 1'b0};
        vecs[13] = '{OP_TICK, 1,  8'h23, 8'h59, 8'h59, 2'd0, 1'b0};
        vecs[14] = '{OP_TICK, 1,  8'h00, 8'h00, 8'h00, 2'd0, 1'b0};
        vecs[15] = '{OP_INC,  1,  8'h00, 8'h00, 8'h00, 2'd0, 1'b0};
        vecs[16] = '{OP_TICK, 61, 8'h00, 8'h01, 8'h01, 2'd0, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", mk(8'h00, 8'h00, 8'h00, 2'd0, 1'b0));
        @(posedge clk); #1 rst = 1'b1;

        for (int i = 0; i < 17; i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                case (vecs[i].op)
                    OP_MODE: press(0);
                    OP_INC:  press(1);
                    default: tick();
                endcase
            end
            @(negedge clk);
            check($sformatf("vec%0d", i), mk(vecs[i].h, vecs[i].m, vecs[i].s, vecs[i].md, vecs[i].bl));
        end

        // Short glitch on mode must be rejected, a long hold accepted.
        @(posedge clk); #1 btn_mode = 1'b1;
        repeat (3) @(posedge clk);
        #1 btn_mode = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("glitch_ignored", mk(8'h00, 8'h01, 8'h01, 2'd0, 1'b0));
        press(0);
        @(negedge clk);
        check("hold_enter_set_hour", mk(8'h00, 8'h01, 8'h00, 2'd1, 1'b0));

        repeat (5) press(1);
        @(negedge clk);
        check("hour_05", mk(8'h05, 8'h01, 8'h00, 2'd1, 1'b0));
        press_both();
        @(negedge clk);
        check("mode_beats_inc", mk(8'h05, 8'h01, 8'h00, 2'd2, 1'b0));
        press(0);
        @(negedge clk);
        check("back_to_run", mk(8'h05, 8'h01, 8'h00, 2'd0, 1'b0));

        repeat (3) tick();
        @(negedge clk);
        check("run_3_ticks", mk(8'h05, 8'h01, 8'h03, 2'd0, 1'b0));

        // Press pulse is registered 6 edges after the raw rise; tick is aligned to that cycle.
        @(posedge clk); #1 btn_mode = 1'b1;
        repeat (6) @(posedge clk);
        #1 tick_1hz = 1'b1;
        @(posedge clk); #1 tick_1hz = 1'b0;
        @(negedge clk);
        check("mode_beats_tick", mk(8'h05, 8'h01, 8'h00, 2'd1, 1'b0));
        btn_mode = 1'b0;
        repeat (10) @(posedge clk);

        repeat (7) press(1);
        press(0);
        repeat (33) press(1);
        press(0);
        repeat (56) tick();
        @(negedge clk);
        check("preload_123456", mk(8'h12, 8'h34, 8'h56, 2'd0, 1'b0));

        #2 rst = 1'b0;
        #1;
        check("async_reset_immediate", mk(8'h00, 8'h00, 8'h00, 2'd0, 1'b0));

        btn_mode = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("held_btn_no_early_pulse", mk(8'h00, 8'h00, 8'h00, 2'd0, 1'b0));
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("held_btn_after_debounce", mk(8'h00, 8'h00, 8'h00, 2'd1, 1'b0));
        btn_mode = 1'b0;
        repeat (10) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
